bram_arbiter: RTL and testbench

- Shares one single-port block RAM (1-cycle synchronous read) between two requesters, e.g. the CPU data port (m0) and the UART loader/debug port (m1).
- Sits between those masters and the BRAM inside dut.
- Round-robin arbitration, with optional burst lock bounded by a starvation counter.
- Tags read data back to the issuing master.

---
 rtl/bram_arbiter.sv | 87 ++++++++
 tb/tb_bram_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port, 1-cycle-latency BRAM between two masters
//
// Ports:
//   clk, reset (async, active-low)
//   mN_req/we/addr/wdata/lock : request side of master N (N = 0, 1)
//   mN_gnt                    : combinational accept, at most one per cycle
//   mN_rvalid/rdata           : read return, one cycle after an accepted read
//   bram_en/we/addr/wdata     : BRAM drive from the granted master
//   bram_rdata                : BRAM read data, valid the cycle after bram_en
module bram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic                m0_lock,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata,
    input  logic [DATA_W-1:0]   bram_rdata
);
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    logic       last_gnt, lock_vld, lock_id, rd_vld, rd_tag;
    logic [7:0] lock_cnt, base_cnt, lock_cnt_d;
    logic       lock_act, gnt, sel_lock, other_req, lock_vld_d, lock_id_d;

    always_comb begin
        // a lock only has force while its owner still has budget left
        lock_act   = lock_vld && lock_cnt < LMAX;
        m0_gnt     = m0_req && (lock_act ? !lock_id : (!m1_req || last_gnt));
        m1_gnt     = m1_req && (lock_act ? lock_id : (!m0_req || !last_gnt));
        gnt        = m0_gnt || m1_gnt;
        sel_lock   = m1_gnt ? m1_lock : m0_lock;
        other_req  = m1_gnt ? m0_req : m1_req;
        // a new owner starts its budget from zero
        base_cnt   = (lock_vld && lock_id == m1_gnt) ? lock_cnt : 8'd0;
        lock_vld_d = gnt ? sel_lock : lock_vld;
        lock_id_d  = gnt ? m1_gnt : lock_id;
        // an idle owner's reservation is charged for each cycle the other master waits
        lock_cnt_d = gnt ? (!sel_lock ? 8'd0 : (other_req && base_cnt < LMAX) ? base_cnt + 8'd1 : base_cnt)
                   : (lock_vld && (lock_id ? m0_req : m1_req) && lock_cnt < LMAX) ? lock_cnt + 8'd1 : lock_cnt;
        bram_en    = gnt;
        bram_we    = m1_gnt ? m1_we : m0_gnt ? m0_we : '0;
        bram_addr  = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
        bram_wdata = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
        m0_rvalid  = rd_vld && !rd_tag;
        m1_rvalid  = rd_vld && rd_tag;
        m0_rdata   = m0_rvalid ? bram_rdata : '0;
        m1_rdata   = m1_rvalid ? bram_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= 1'b1;
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
            lock_cnt <= 8'd0;
            rd_vld   <= 1'b0;
            rd_tag   <= 1'b0;
        end else begin
            if (gnt) last_gnt <= m1_gnt;
            lock_vld <= lock_vld_d;
            lock_id  <= lock_id_d;
            lock_cnt <= lock_cnt_d;
            rd_vld   <= gnt && bram_we == '0;
            rd_tag   <= m1_gnt;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench for bram_arbiter with a behavioural BRAM
module tb_bram_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        m0_req = 0, m0_lock = 0, m1_req = 0, m1_lock = 0;
    logic [3:0]  m0_we = 0, m1_we = 0;
    logic [9:0]  m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en;
    logic [31:0] m0_rdata, m1_rdata, bram_wdata, bram_rdata;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;

    bram_arbiter #(.ADDR_W(10), .DATA_W(32), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        m;
        logic [31:0] d;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rvalid", sb[0].m ? m1_rvalid : m0_rvalid, 1);
                check("rdata", sb[0].m ? m1_rdata : m0_rdata, sb[0].d);
                check("other_rvalid", sb[0].m ? m0_rvalid : m1_rvalid, 0);
                check("other_rdata", sb[0].m ? m0_rdata : m1_rdata, 0);
                void'(sb.pop_front());
            end else begin
                check("no_rvalid", {m0_rvalid, m1_rvalid}, 0);
                check("idle_rdata", m0_rdata | m1_rdata, 0);
            end
        end
    end

    task automatic commit(input logic m, input logic [3:0] we, input logic [9:0] a, input logic [31:0] wd);
        exp_t e;
        if (we == 4'b0) begin
            e.m = m;
            e.d = ref_mem[a];
            e.due = cyc + 1;
            sb.push_back(e);
        end else begin
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // one cycle with the current inputs; expected grants given by the caller
    task automatic step(input logic e0, input logic e1);
        @(negedge clk);
        check("m0_gnt", m0_gnt, e0);
        check("m1_gnt", m1_gnt, e1);
        check("bram_en", bram_en, e0 | e1);
        if (e0 | e1) begin
            check("bram_addr", bram_addr, e1 ? m1_addr : m0_addr);
            check("bram_we", bram_we, e1 ? m1_we : m0_we);
            check("bram_wdata", bram_wdata, e1 ? m1_wdata : m0_wdata);
        end else
            check("bram_we_idle", bram_we, 0);
        if (e0) commit(1'b0, m0_we, m0_addr, m0_wdata);
        if (e1) commit(1'b1, m1_we, m1_addr, m1_wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA5A50000 ^ (i * 32'h00010001);
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        #7;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("rst_lock_cnt", dut.lock_cnt, 0);
        check("rst_last_gnt", dut.last_gnt, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // single read by m0
        m0_req = 1; m0_addr = 10'h005;
        step(1, 0);
        m0_req = 0;
        step(0, 0);

        // continuous contention without lock; m0 won last, so m1 leads
        m0_req = 1; m1_req = 1; m0_addr = 10'h010; m1_addr = 10'h100;
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 1, i % 2 == 0);
            if (i % 2 == 1) m0_addr = m0_addr + 1;
            else m1_addr = m1_addr + 1;
        end
        m0_req = 0; m1_req = 0;
        step(0, 0);

        // partial byte write by m1, then read back by m0
        m1_req = 1; m1_we = 4'b0011; m1_addr = 10'h3FF; m1_wdata = 32'h12345678;
        step(0, 1);
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_addr = 10'h3FF;
        step(1, 0);
        m0_req = 0;
        step(0, 0);

        // m1 burst lock against continuous m0 requests
        m1_req = 1; m1_lock = 1; m1_addr = 10'h050;
        step(0, 1);
        m0_req = 1; m0_addr = 10'h060;
        for (int i = 0; i < 8; i++) begin
            m1_addr = m1_addr + 1;
            step(0, 1);
        end
        step(1, 0);
        check("lock_cnt_clear", dut.lock_cnt, 0);
        check("lock_owner_clear", dut.lock_vld, 0);
        m0_req = 0; m1_req = 0; m1_lock = 0;
        step(0, 0);

        // idle lock owner reserves the port for LOCK_MAX cycles
        m0_req = 1; m0_lock = 1; m0_addr = 10'h070;
        step(1, 0);
        m0_req = 0; m1_req = 1; m1_addr = 10'h080;
        for (int i = 0; i < 8; i++) step(0, 0);
        step(0, 1);
        m1_req = 0; m0_lock = 0;
        step(0, 0);

        // reset on the cycle after a granted read drops the rvalid
        m0_req = 1; m0_addr = 10'h090;
        step(1, 0);
        m0_req = 0;
        reset = 1'b0;
        sb.delete();
        #1;
        check("rst_drop_rvalid", m0_rvalid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m0_req = 1; m1_req = 1; m0_addr = 10'h0A0; m1_addr = 10'h0B0;
        step(1, 0);
        m0_req = 0;
        step(0, 1);
        m1_req = 0;
        step(0, 0);
        step(0, 0);
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
